rom_load_ctrl: RTL and testbench

//  Owns the 4096x8 program ROM of the sm510 core; shares its single memory port between the host

---
 rtl/gw_rom_pkg.sv | 16 +
 rtl/rom_sp_ram.sv | 29 ++
 rtl/rom_load_ctrl.sv | 149 ++++++++++++++
 tb/tb_rom_load_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/gw_rom_pkg.sv
// Shared types and constants for the sm510 program ROM loader.
package gw_rom_pkg;

  localparam int unsigned ROM_DEPTH = 4096;

  typedef logic [11:0] rom_addr_t;
  typedef logic [7:0]  rom_data_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD,
    S_RUN
  } rom_load_state_t;

endpackage

// File: rtl/rom_sp_ram.sv
// Single-port synchronous RAM with a 1-cycle read; rdata holds while re_i is low. No reset.
module rom_sp_ram #(
  parameter int unsigned AddrWidth = 12,
  parameter int unsigned DataWidth = 8,
  parameter int unsigned Depth     = 4096
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic                 re_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic [DataWidth-1:0] rdata_o
);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [DataWidth-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/rom_load_ctrl.sv
// Shares the sm510 program ROM port between host download and CPU fetch, holding the CPU in reset
// around downloads. Optional checksum of downloaded bytes: define ROM_LOAD_CHECKSUM_EN.
module rom_load_ctrl
  import gw_rom_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ROM_DEPTH  = gw_rom_pkg::ROM_DEPTH,
  parameter int unsigned RESET_HOLD = 4
) (
  input  logic                        clk_i,
  input  logic                        reset_ni,
  input  logic                        dl_active_i,
  input  logic                        dl_valid_i,
  output logic                        dl_ready_o,
  input  logic [ADDR_WIDTH-1:0]       dl_addr_i,
  input  logic [DATA_WIDTH-1:0]       dl_data_i,
  input  logic                        cpu_clk_en_i,
  input  logic [ADDR_WIDTH-1:0]       cpu_rom_addr_i,
  output logic [DATA_WIDTH-1:0]       cpu_rom_data_o,
  output logic                        cpu_reset_o,
  output logic                        load_done_o,
  output logic                        load_overflow_o,
  output logic [$clog2(ROM_DEPTH):0]  bytes_loaded_o,
  output logic [7:0]                  rom_checksum_o
);

  localparam int unsigned IdxWidth = $clog2(ROM_DEPTH);
  localparam int unsigned CntWidth = IdxWidth + 1;

  rom_load_state_t     state_q;
  logic                cpu_reset_q, dl_ready_q, load_done_q, overflow_q;
  logic [CntWidth-1:0] bytes_q;
  logic [3:0]          hold_q;
  logic                rd_zero_q;

  logic                dl_in_range, cpu_in_range;
  logic                xfer, dl_we, fetch, rd_en, load_start;
  logic [IdxWidth-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign dl_in_range  = {{(32-ADDR_WIDTH){1'b0}}, dl_addr_i} < ROM_DEPTH;
  assign cpu_in_range = {{(32-ADDR_WIDTH){1'b0}}, cpu_rom_addr_i} < ROM_DEPTH;

  // dl_ready_q is only high in S_LOAD, so writes can never collide with fetches.
  assign xfer       = dl_valid_i && dl_ready_q;
  assign dl_we      = xfer && dl_in_range;
  assign fetch      = (state_q == S_RUN) && cpu_clk_en_i;
  assign rd_en      = fetch && cpu_in_range;
  assign load_start = dl_active_i && (state_q != S_LOAD);
  assign ram_addr   = (state_q == S_LOAD) ? dl_addr_i[IdxWidth-1:0]
                                          : cpu_rom_addr_i[IdxWidth-1:0];

  rom_sp_ram #(
    .AddrWidth(IdxWidth),
    .DataWidth(DATA_WIDTH),
    .Depth    (ROM_DEPTH)
  ) u_ram (
    .clk_i  (clk_i),
    .we_i   (dl_we),
    .re_i   (rd_en),
    .addr_i (ram_addr),
    .wdata_i(dl_data_i),
    .rdata_o(ram_rdata)
  );

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= S_IDLE;
      cpu_reset_q <= 1'b1;
      dl_ready_q  <= 1'b0;
      load_done_q <= 1'b0;
      overflow_q  <= 1'b0;
      bytes_q     <= '0;
      hold_q      <= '0;
    end else if (load_start) begin
      state_q     <= S_LOAD;
      cpu_reset_q <= 1'b1;
      dl_ready_q  <= 1'b1;
      load_done_q <= 1'b0;
      overflow_q  <= 1'b0;
      bytes_q     <= '0;
    end else begin
      unique case (state_q)
        S_LOAD: begin
          if (dl_we && (bytes_q != CntWidth'(ROM_DEPTH))) begin
            bytes_q <= bytes_q + 1'b1;
          end
          if (xfer && !dl_in_range) begin
            overflow_q <= 1'b1;
          end
          if (!dl_active_i) begin
            state_q    <= S_HOLD;
            dl_ready_q <= 1'b0;
            hold_q     <= 4'(RESET_HOLD);
          end
        end
        S_HOLD: begin
          if (cpu_clk_en_i) begin
            hold_q <= hold_q - 4'd1;
            if (hold_q == 4'd1) begin
              state_q     <= S_RUN;
              cpu_reset_q <= 1'b0;
              load_done_q <= 1'b1;
            end
          end
        end
        S_IDLE, S_RUN: ;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // RAM output register acts as the fetch register; this flag forces 0 after reset or an
  // out-of-range fetch.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rd_zero_q <= 1'b1;
    end else if (fetch) begin
      rd_zero_q <= !cpu_in_range;
    end
  end

`ifdef ROM_LOAD_CHECKSUM_EN
  rom_data_t csum_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      csum_q <= '0;
    end else if (load_start) begin
      csum_q <= '0;
    end else if (dl_we) begin
      csum_q <= csum_q + dl_data_i[7:0];
    end
  end

  assign rom_checksum_o = csum_q;
`else
  assign rom_checksum_o = 8'h00;
`endif

  assign cpu_rom_data_o  = rd_zero_q ? '0 : ram_rdata;
  assign cpu_reset_o     = cpu_reset_q;
  assign dl_ready_o      = dl_ready_q;
  assign load_done_o     = load_done_q;
  assign load_overflow_o = overflow_q;
  assign bytes_loaded_o  = bytes_q;

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Self-checking bench for rom_load_ctrl (13-bit address build so out-of-range bytes are reachable).
`timescale 1ns/1ps
module tb_rom_load_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        dl_active, dl_valid, dl_ready;
  logic [12:0] dl_addr;
  logic [7:0]  dl_data;
  logic        cpu_clk_en;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_rom_data;
  logic        cpu_reset, load_done, load_overflow;
  logic [12:0] bytes_loaded;
  logic [7:0]  rom_checksum;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mem [4096];
  logic [7:0]  csum;
  logic [7:0]  last_data;
  logic        fetch_arm;
  int          ph, n_en, n0;
  logic [7:0]  sb[$];

  always #5 clk = ~clk;

  rom_load_ctrl #(
    .ADDR_WIDTH(13),
    .DATA_WIDTH(8),
    .ROM_DEPTH (4096),
    .RESET_HOLD(4)
  ) dut (
    .clk_i          (clk),
    .reset_ni       (reset_n),
    .dl_active_i    (dl_active),
    .dl_valid_i     (dl_valid),
    .dl_ready_o     (dl_ready),
    .dl_addr_i      (dl_addr),
    .dl_data_i      (dl_data),
    .cpu_clk_en_i   (cpu_clk_en),
    .cpu_rom_addr_i (cpu_addr),
    .cpu_rom_data_o (cpu_rom_data),
    .cpu_reset_o    (cpu_reset),
    .load_done_o    (load_done),
    .load_overflow_o(load_overflow),
    .bytes_loaded_o (bytes_loaded),
    .rom_checksum_o (rom_checksum)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] cs_exp();
`ifdef ROM_LOAD_CHECKSUM_EN
    return csum;
`else
    return 8'h00;
`endif
  endfunction

  // One clock: scoreboard a fetch if the CPU is running and enabled, then compare after the edge.
  task automatic tick();
    logic fetch_now;
    fetch_now = fetch_arm && cpu_clk_en;
    if (fetch_now) sb.push_back((cpu_addr < 13'h1000) ? mem[cpu_addr[11:0]] : 8'h00);
    @(posedge clk);
    #1;
    if (cpu_clk_en) n_en++;
    if (fetch_now) begin
      last_data = sb.pop_front();
      check("fetch", {24'd0, cpu_rom_data}, {24'd0, last_data});
    end else if (fetch_arm) begin
      check("hold_data", {24'd0, cpu_rom_data}, {24'd0, last_data});
    end
    ph++;
    cpu_clk_en = (ph % 4 == 0);
  endtask

  task automatic send(input logic [12:0] a, input logic [7:0] d);
    dl_valid = 1'b1;
    dl_addr  = a;
    dl_data  = d;
    if (a < 13'h1000) begin
      mem[a[11:0]] = d;
      csum = csum + d;
    end
    tick();
    dl_valid = 1'b0;
  endtask

  task automatic wait_run();
    for (int i = 0; i < 200 && cpu_reset; i++) tick();
    check("run_reached", {31'd0, cpu_reset}, 32'd0);
    check("hold_en_count", n_en - n0, 32'd4);
    check("load_done_run", {31'd0, load_done}, 32'd1);
  endtask

  task automatic fetch_at(input logic [12:0] a);
    cpu_addr = a;
    for (int i = 0; i < 4; i++) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic rst_ok;
    reset_n = 1'b0; dl_active = 1'b0; dl_valid = 1'b0; dl_addr = '0; dl_data = '0;
    cpu_clk_en = 1'b0; cpu_addr = '0; fetch_arm = 1'b0; last_data = 8'h00;
    ph = 0; n_en = 0; n0 = 0; csum = 8'h00;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    #12;
    check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("rst_dl_ready", {31'd0, dl_ready}, 32'd0);
    check("rst_data", {24'd0, cpu_rom_data}, 32'd0);
    check("rst_done", {31'd0, load_done}, 32'd0);
    check("rst_bytes", {19'd0, bytes_loaded}, 32'd0);
    check("rst_csum", {24'd0, rom_checksum}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Reset in the middle of a download.
    dl_active = 1'b1;
    tick();
    check("load_ready", {31'd0, dl_ready}, 32'd1);
    send(13'h010, 8'h77);
    send(13'h011, 8'h88);
    check("mid_bytes", {19'd0, bytes_loaded}, 32'd2);
    #2 reset_n = 1'b0;
    #1;
    check("async_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("async_dl_ready", {31'd0, dl_ready}, 32'd0);
    check("async_bytes", {19'd0, bytes_loaded}, 32'd0);
    check("async_done", {31'd0, load_done}, 32'd0);
    dl_active = 1'b0;
    #1 reset_n = 1'b1;
    tick(); tick();
    check("idle_ready", {31'd0, dl_ready}, 32'd0);
    check("idle_cpu_reset", {31'd0, cpu_reset}, 32'd1);

    // Full download; last byte offered in the same cycle dl_active drops.
    csum = 8'h00;
    dl_active = 1'b1;
    tick();
    for (int a = 0; a < 4095; a++) send(13'(a), 8'(a));
    dl_active = 1'b0;
    send(13'hFFF, 8'hFF);
    n0 = n_en;
    dl_valid = 1'b1; dl_addr = 13'h1000; dl_data = 8'h99;
    tick();
    check("hold_ready", {31'd0, dl_ready}, 32'd0);
    wait_run();
    dl_valid = 1'b0;
    check("full_bytes", {19'd0, bytes_loaded}, 32'd4096);
    check("full_ovf", {31'd0, load_overflow}, 32'd0);
    check("full_csum", {24'd0, rom_checksum}, {24'd0, cs_exp()});

    // Fetches in run mode.
    fetch_arm = 1'b1;
    fetch_at(13'h123);
    fetch_at(13'h123);
    fetch_at(13'hFFF);
    fetch_at(13'h1000);
    fetch_at(13'h07E);

    // Restart a download from run mode, with one out-of-range byte.
    dl_active = 1'b1;
    tick();
    fetch_arm = 1'b0;
    csum = 8'h00;
    check("restart_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("restart_done", {31'd0, load_done}, 32'd0);
    check("restart_bytes", {19'd0, bytes_loaded}, 32'd0);
    check("restart_csum", {24'd0, rom_checksum}, 32'd0);
    send(13'h005, 8'h0A);
    send(13'h1000, 8'h55);
    check("ovf_flag", {31'd0, load_overflow}, 32'd1);
    check("ovf_bytes", {19'd0, bytes_loaded}, 32'd1);
    check("ovf_csum", {24'd0, rom_checksum}, {24'd0, cs_exp()});

    // Re-enter the download with the hold counter at 2.
    dl_active = 1'b0;
    tick();
    n0 = n_en;
    rst_ok = 1'b1;
    for (int i = 0; i < 40 && (n_en - n0) < 2; i++) begin
      tick();
      rst_ok &= cpu_reset;
    end
    dl_active = 1'b1;
    tick();
    rst_ok &= cpu_reset;
    check("rehold_no_release", {31'd0, rst_ok}, 32'd1);
    check("rehold_ready", {31'd0, dl_ready}, 32'd1);
    check("rehold_ovf", {31'd0, load_overflow}, 32'd0);
    dl_active = 1'b0;
    tick();
    n0 = n_en;
    wait_run();

    fetch_arm = 1'b1;
    fetch_at(13'h005);
    fetch_at(13'h000);
    fetch_at(13'h006);
    fetch_arm = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
